mux_nto1_stream_reg: RTL and testbench
======================================

// Module: mux_nto1_stream_reg
// PURPOSE
//   Registered N-input stream multiplexer with valid/ready handshake on every port.
//   Each cycle it selects one requesting input, using fixed-priority, round-robin or
//   externally forced selection, and places that word in a one-entry output register.
//   It merges the datapath sources of the pipelined CPU core (ALU, memory, immediate,
//   PC+1 and similar) onto one write-back bus.
// PARAMETERS
//   WIDTH  24  data width of every input and of the output
//   N      4   number of inputs, N >= 2
//   MODE   1   0 = fixed priority (lowest index wins); 1 = round-robin; 2 = forced by Sel
//   SELW   localparam = $clog2(N); width of Sel and OutSrc
// PORTS
//   Clock    in   1        rising-edge clock
//   Reset_n  in   1        asynchronous active-low reset
//   InValid  in   N        InValid[i] = input i presents a word
//   InData   in   N*WIDTH  input i is InData[i*WIDTH +: WIDTH]
//   InReady  out  N        InReady[i] = input i transfers this cycle
//   Sel      in   SELW     forced input index; used only when MODE = 2
//   OutValid out  1        output register holds a valid word
//   OutData  out  WIDTH    registered output word
//   OutSrc   out  SELW     index of the input that supplied OutData
//   OutReady in   1        consumer accepts OutData this cycle
// BEHAVIOUR
//   - Reset (Reset_n = 0, asynchronous):
//     - OutValid = 0, OutData = 0, OutSrc = 0, round-robin pointer Ptr = 0.
//     - Asserting reset mid-transfer discards any held word.
//   - Load = ~OutValid | OutReady. It is combinational and gives full throughput
//     (1 word/cycle) when OutReady is held high.
//   - Grant is a combinational one-hot over InValid. InReady = grant & {N{Load}}.
//     At most one InReady bit is high.
//   - A transfer from input i happens when InValid[i] & InReady[i]. On that clock edge:
//     - OutData <= word i; OutSrc <= i; OutValid <= 1.
//   - If Load is high and no input is granted: OutValid <= 0 on the clock edge.
//     OutData and OutSrc keep their previous values.
//   - If OutValid = 1 and OutReady = 0: OutData, OutSrc and OutValid hold stable.
//     All InReady bits are 0.
//   - Latency is 1 cycle from input transfer to OutValid. There is no combinational path
//     from InData to OutData.
//   - MODE 0: grant goes to the lowest i with InValid[i] = 1. Ptr is unused and stays 0.
//   - MODE 1: the search starts at index Ptr and wraps from N-1 to 0. The first valid
//     input is granted.
//     - After a transfer from input i: Ptr <= (i+1) mod N. Ptr at N-1 wraps to 0.
//     - Ptr changes only on a transfer, never on idle or stall cycles.
//   - MODE 2: grant goes only to input Sel, when InValid[Sel] = 1.
//     - If Sel >= N (non-power-of-2 N), nothing is granted.
//     - Sel is sampled combinationally each cycle. Changing Sel while stalled does not
//       affect the held word.
//   - Input contract: InData[i] must stay stable while InValid[i] = 1 and InReady[i] = 0.
//     An input never sees InReady without its own InValid.
// TESTING  (WIDTH = 24, N = 4)
//   1. Reset: Reset_n = 0 mid-stream, with OutValid = 1 and OutData = 24'hABCDEF.
//      -> OutValid, OutData and OutSrc read 0 immediately, asynchronously, before the
//      next clock edge. Ptr = 0.
//   2. MODE 0: InValid = 4'b1010, data words 24'h111111 to 24'h444444, OutReady = 1.
//      -> InReady = 4'b0010. Next cycle OutData = 24'h222222, OutSrc = 1. Input 3 waits
//      until InValid[1] drops.
//   3. MODE 1: InValid = 4'b1111 held, OutReady = 1.
//      -> OutSrc sequence is 0,1,2,3,0,1 on consecutive cycles. Ptr wraps from 3 to 0
//      and OutValid stays high throughout.
//   4. Backpressure, with OutValid = 1, OutData = 24'h00FFEE and OutReady = 0 for
//      3 cycles: -> OutData is stable and InReady = 0.
//      Then OutReady = 1 -> the next word loads in the same cycle and there is no bubble.
//   5. MODE 2: first Sel = 2 with InValid = 4'b1011 -> no grant; OutValid falls to 0
//      after the drain. Then Sel = 3 -> InReady = 4'b1000 and OutSrc = 3.

Source files
------------

// File: rtl/mux_nto1_stream_reg.sv
// Registered N:1 stream mux (fixed-priority / round-robin / forced select) into a one-entry output register.
// 1-cycle latency; a stalled output register drops every InReady, and a draining one reloads in the same cycle.
module mux_nto1_stream_reg #(
   parameter int WIDTH = 24,
   parameter int N     = 4,
   parameter int MODE  = 1,
   localparam int SELW = (N > 1) ? $clog2(N) : 1
) (
   input  logic                 Clock,
   input  logic                 Reset_n,
   input  logic [N-1:0]         InValid,
   input  logic [N*WIDTH-1:0]   InData,
   output logic [N-1:0]         InReady,
   input  logic [SELW-1:0]      Sel,
   output logic                 OutValid,
   output logic [WIDTH-1:0]     OutData,
   output logic [SELW-1:0]      OutSrc,
   input  logic                 OutReady
);

   logic [SELW-1:0]  ptr_q, ptr_d;
   logic             vld_q, vld_d;
   logic [WIDTH-1:0] dat_q, dat_d;
   logic [SELW-1:0]  src_q, src_d;

   logic [N-1:0]     gnt;
   logic [SELW-1:0]  gnt_idx;
   logic             gnt_any;
   logic             load;
   logic             xfer;

   always_comb begin
      int rr_idx;
      rr_idx  = 0;
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      if (MODE == 0) begin
         // Descending scan so the lowest valid index is the last one written.
         for (int i = N - 1; i >= 0; i--) begin
            if (InValid[i]) begin
               gnt_idx = SELW'(i);
               gnt_any = 1'b1;
            end
         end
      end else if (MODE == 1) begin
         for (int k = N - 1; k >= 0; k--) begin
            rr_idx = (int'(ptr_q) + k) % N;
            if (InValid[rr_idx]) begin
               gnt_idx = SELW'(rr_idx);
               gnt_any = 1'b1;
            end
         end
      end else begin
         if ((int'(Sel) < N) && InValid[Sel]) begin
            gnt_idx = Sel;
            gnt_any = 1'b1;
         end
      end
      if (gnt_any) begin
         gnt[gnt_idx] = 1'b1;
      end
   end

   assign load    = ~vld_q | OutReady;
   assign xfer    = load & gnt_any;
   assign InReady = gnt & {N{load}};

   always_comb begin
      vld_d = vld_q;
      dat_d = dat_q;
      src_d = src_q;
      ptr_d = ptr_q;
      if (xfer) begin
         vld_d = 1'b1;
         dat_d = InData[gnt_idx*WIDTH +: WIDTH];
         src_d = gnt_idx;
         if (MODE == 1) begin
            ptr_d = (gnt_idx == SELW'(N - 1)) ? '0 : gnt_idx + 1'b1;
         end
      end else if (load) begin
         vld_d = 1'b0;
      end
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         vld_q <= 1'b0;
         dat_q <= '0;
         src_q <= '0;
         ptr_q <= '0;
      end else begin
         vld_q <= vld_d;
         dat_q <= dat_d;
         src_q <= src_d;
         ptr_q <= ptr_d;
      end
   end

   assign OutValid = vld_q;
   assign OutData  = dat_q;
   assign OutSrc   = src_q;

endmodule

// File: tb/tb_mux_nto1_stream_reg.sv
// Bench for mux_nto1_stream_reg: one instance per arbitration mode sharing the stimulus,
// with a scoreboard of {src, data} words popped whenever the monitored output hands off.
module tb_mux_nto1_stream_reg;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  in_vld;
   logic [95:0] in_dat;
   logic [1:0]  sel;
   logic        out_rdy;

   logic [3:0]  fp_ir, rr_ir, fs_ir;
   logic        fp_ov, rr_ov, fs_ov;
   logic [23:0] fp_od, rr_od, fs_od;
   logic [1:0]  fp_os, rr_os, fs_os;

   int          n_chk  = 0;
   int          n_pass = 0;
   int          mon    = -1;
   logic [25:0] sb[$];
   logic        m_ov;
   logic [25:0] m_got;
   logic [25:0] m_exp;

   always #5 clk = ~clk;

   mux_nto1_stream_reg #(.WIDTH(24), .N(4), .MODE(0)) u_fp (
      .Clock(clk), .Reset_n(rst_n), .InValid(in_vld), .InData(in_dat), .InReady(fp_ir),
      .Sel(sel), .OutValid(fp_ov), .OutData(fp_od), .OutSrc(fp_os), .OutReady(out_rdy));
   mux_nto1_stream_reg #(.WIDTH(24), .N(4), .MODE(1)) u_rr (
      .Clock(clk), .Reset_n(rst_n), .InValid(in_vld), .InData(in_dat), .InReady(rr_ir),
      .Sel(sel), .OutValid(rr_ov), .OutData(rr_od), .OutSrc(rr_os), .OutReady(out_rdy));
   mux_nto1_stream_reg #(.WIDTH(24), .N(4), .MODE(2)) u_fs (
      .Clock(clk), .Reset_n(rst_n), .InValid(in_vld), .InData(in_dat), .InReady(fs_ir),
      .Sel(sel), .OutValid(fs_ov), .OutData(fs_od), .OutSrc(fs_os), .OutReady(out_rdy));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, required %h", tag, got, exp);
   endtask

   always_comb begin
      m_ov  = 1'b0;
      m_got = '0;
      case (mon)
         0: begin m_ov = fp_ov; m_got = {fp_os, fp_od}; end
         1: begin m_ov = rr_ov; m_got = {rr_os, rr_od}; end
         2: begin m_ov = fs_ov; m_got = {fs_os, fs_od}; end
         default: ;
      endcase
   end

   always @(negedge clk) begin
      if (mon >= 0 && m_ov && out_rdy) begin
         if (sb.size() == 0) begin
            n_chk++;
            $display("FAIL sb_pop: got word %h, required none", m_got);
         end else begin
            m_exp = sb.pop_front();
            chk("sb_word", 32'(m_got), 32'(m_exp));
         end
      end
   end

   task automatic set_word(input int i, input logic [23:0] w);
      in_dat[i*24 +: 24] = w;
   endtask

   task automatic do_reset();
      in_vld  = '0;
      out_rdy = 1'b0;
      sel     = '0;
      rst_n   = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      in_dat = '0;
      do_reset();

      // Reset asserted while a word is held must clear the outputs before the next edge.
      mon = -1;
      set_word(0, 24'hABCDEF);
      in_vld = 4'b0001;
      @(posedge clk);
      #2;
      chk("rst_pre_ov", 32'(rr_ov), 32'd1);
      chk("rst_pre_od", 32'(rr_od), 32'hABCDEF);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_ov", 32'(rr_ov), 32'd0);
      chk("rst_od", 32'(rr_od), 32'd0);
      chk("rst_os", 32'(rr_os), 32'd0);
      chk("rst_fp_ov", 32'(fp_ov), 32'd0);

      // Fixed priority: input 1 beats input 3 until it drops.
      do_reset();
      mon = 0;
      set_word(0, 24'h111111); set_word(1, 24'h222222);
      set_word(2, 24'h333333); set_word(3, 24'h444444);
      out_rdy = 1'b1;
      in_vld  = 4'b1010;
      sb.push_back({2'd1, 24'h222222});
      @(negedge clk);
      chk("fp_ir_a", 32'(fp_ir), 32'b0010);
      @(posedge clk);
      #1 sb.push_back({2'd1, 24'h222222});
      @(posedge clk);
      #1 in_vld = 4'b1000;
      sb.push_back({2'd3, 24'h444444});
      @(negedge clk);
      chk("fp_ir_b", 32'(fp_ir), 32'b1000);
      @(posedge clk);
      #1 in_vld = '0;
      repeat (3) @(posedge clk);
      chk("fp_sb_empty", 32'(sb.size()), 32'd0);

      // Round robin with all inputs requesting: 0,1,2,3,0,1 back to back.
      do_reset();
      mon = 1;
      out_rdy = 1'b1;
      in_vld  = 4'b1111;
      sb.push_back({2'd0, 24'h111111}); sb.push_back({2'd1, 24'h222222});
      sb.push_back({2'd2, 24'h333333}); sb.push_back({2'd3, 24'h444444});
      sb.push_back({2'd0, 24'h111111}); sb.push_back({2'd1, 24'h222222});
      for (int k = 0; k < 6; k++) begin
         @(posedge clk);
         #1 chk("rr_ov_cont", 32'(rr_ov), 32'd1);
      end
      in_vld = '0;
      repeat (3) @(posedge clk);
      #1 chk("rr_drain_ov", 32'(rr_ov), 32'd0);
      chk("rr_sb_empty", 32'(sb.size()), 32'd0);

      // Backpressure: held word stable, then reload with no bubble.
      do_reset();
      mon = 0;
      set_word(0, 24'h00FFEE);
      in_vld = 4'b0001;
      sb.push_back({2'd0, 24'h00FFEE});
      @(posedge clk);
      #1 set_word(0, 24'h123456);
      sb.push_back({2'd0, 24'h123456});
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bp_od_hold", 32'(fp_od), 32'h00FFEE);
         chk("bp_ir_zero", 32'(fp_ir), 32'd0);
         @(posedge clk);
         #1;
      end
      out_rdy = 1'b1;
      @(negedge clk);
      chk("bp_ir_reload", 32'(fp_ir), 32'b0001);
      @(posedge clk);
      #1 in_vld = '0;
      chk("bp_ov_nobubble", 32'(fp_ov), 32'd1);
      repeat (2) @(posedge clk);
      chk("bp_sb_empty", 32'(sb.size()), 32'd0);

      // Forced select: Sel on an idle input grants nothing and drains.
      do_reset();
      mon = 2;
      out_rdy = 1'b1;
      sel     = 2'd3;
      in_vld  = 4'b1000;
      set_word(3, 24'h444444);
      sb.push_back({2'd3, 24'h444444});
      @(posedge clk);
      #1 sel = 2'd2;
      in_vld = 4'b1011;
      @(negedge clk);
      chk("fs_ir_none", 32'(fs_ir), 32'd0);
      @(posedge clk);
      #1 chk("fs_ov_drain", 32'(fs_ov), 32'd0);
      sel = 2'd3;
      set_word(3, 24'h777777);
      sb.push_back({2'd3, 24'h777777});
      @(negedge clk);
      chk("fs_ir_sel3", 32'(fs_ir), 32'b1000);
      @(posedge clk);
      #1 in_vld = '0;
      repeat (2) @(posedge clk);
      chk("fs_sb_empty", 32'(sb.size()), 32'd0);
      mon = -1;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
